ls_rs_ordered: RTL and testbench
================================

Name: ls_rs_ordered

Overview:
- Parametrised load/store reservation station; sits between instruction dispatch and the load/store buffer.
- Each entry holds a base operand, a store-data operand and an immediate, and snoops N wakeup broadcast channels (CDB, LS-CDB, ROB, register file) for missing operands.
- Issues the oldest fully-ready entry through a registered output stage with valid/accept backpressure, carrying the effective address base+imm.
- Successor to the fixed 8-entry station: adds explicit dependency valid bits, age-ordered issue and downstream flow control.

Parameters:
- DEPTH, 8, number of entries (power of 2, >=4)
- ROB_W, 5, ROB tag width
- XLEN, 32, data width
- NWAKE, 5, number of wakeup broadcast channels

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low freezes all state
- _clear  in  1  pipeline flush
- _rs_ready  in  1  dispatch insert strobe
- _rs_type  in  7  opcode/funct tag, passed through
- _rs_rob_id  in  ROB_W  destination ROB tag
- _rs_r1  in  XLEN  base value
- _rs_sv  in  XLEN  store data value
- _rs_imm  in  XLEN  offset
- _rs_has_dep1 / _rs_has_dep2  in  1  operand pending
- _rs_dep1 / _rs_dep2  in  ROB_W  producer tags
- _rs_full  out  1  no further insert accepted
- _wk_ready  in  NWAKE  per-channel broadcast valid
- _wk_rob_id  in  NWAKE*ROB_W  channel k at bits [k*ROB_W +: ROB_W]
- _wk_value  in  NWAKE*XLEN  channel k at bits [k*XLEN +: XLEN]
- _lsb_valid  out  1  output stage holds an entry
- _lsb_accept  in  1  consumer takes output this cycle
- _lsb_rob_id  out  ROB_W; _lsb_type out 7; _lsb_st_value out XLEN; _lsb_ptr_value out XLEN (base+imm, mod 2^XLEN)

Behaviour:
- Reset or _clear (rst_in has priority, _clear next; both override rdy_in gating): all busy, pend1, pend2 bits = 0; count = 0; _lsb_valid = 0; all output data = 0. Same-cycle insert is dropped.
- rdy_in = 0: no state changes; outputs hold; wakeups in that cycle are lost.
- Entry state: busy, pend1/pend2 (explicit bits, so ROB tag 0 is a legal dependency), tags, v1, sv, imm, type, rob_id, age rank.
- _rs_full = (count >= DEPTH-1), so one slot of slack remains for a registered dispatcher. An insert while count == DEPTH is ignored.
- Insert: written into the lowest-index free slot with age rank = count (0 = oldest).
- Insert bypass: if has_depX and any channel k has _wk_ready[k] and a matching tag, the operand takes that value and pendX = 0; the lowest k wins.
- Wakeup: for every busy entry and each pending operand, a match on any ready channel captures the value and clears pend. Multiple matching channels: lowest k wins. A non-pending operand ignores broadcasts.
- Entry ready = busy & !pend1 & !pend2. Selection = ready entry with the smallest age rank.
- Output stage load: when (!_lsb_valid | _lsb_accept) and a selection exists, at the clock edge:
  - copy rob_id, type, sv and v1+imm into the output registers;
  - set _lsb_valid = 1;
  - free the entry;
  - decrement the rank of every entry whose rank exceeds the freed rank.
- Output stage drain: if _lsb_accept with no selection, _lsb_valid -> 0. While _lsb_valid & !_lsb_accept, output data is held stable.
- Latency: an entry inserted fully ready at edge N is presented on the output after edge N+1.
- Simultaneous insert + pop: count unchanged. The new entry's rank = count - 1 (it stays youngest after the decrement). The freed slot is not reused in the same cycle.
- _lsb_accept while !_lsb_valid: ignored.

Optional Feature:
- LS_RS_STRICT_ORDER_EN defined: only the rank-0 entry may be selected. A younger ready entry waits until all older entries have issued (full program-order memory issue).
- Undefined: oldest-ready selection as above.

Test Plan:
- Reset, then insert rob 3, r1=0x100, imm=0x8, no deps, accept=1 -> _lsb_valid=1 after 2 edges, ptr=0x108, rob=3; _rs_full=0.
- Insert rob 1 dep1=tag 0, then rob 2 ready; broadcast tag 0 value 0x40 on channel 4 -> rob 2 issues first. Rob 1 issues next with ptr=0x40+imm (tag 0 must not be treated as ready before the broadcast).
- Insert rob 5 with dep2=7 while channels 0 and 2 both broadcast tag 7 (0xA, 0xB) -> captured st_value=0xA, issues next cycle.
- Fill 7 entries -> _rs_full=1. Hold accept=0 -> output unchanged for 10 cycles. Raise accept -> one issue per cycle in age order, count returns to 0.
- _clear with 4 entries and _lsb_valid=1 -> next cycle _lsb_valid=0, _rs_full=0, no issues follow. Repeat with rst_in and rdy_in=0 -> same result.
- With LS_RS_STRICT_ORDER_EN: oldest entry pending, younger ready -> no issue until the broadcast. Without the macro: the younger entry issues immediately.

Source files
------------

// File: rtl/ls_rs_ordered.sv
// Load/store reservation station: operand snooping, age-ranked issue, registered output stage.
// Optional macro LS_RS_STRICT_ORDER_EN restricts issue to the oldest (rank-0) entry.
module ls_rs_ordered #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned ROB_W = 5,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NWAKE = 5
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   _clear,
  input  logic                   _rs_ready,
  input  logic [6:0]             _rs_type,
  input  logic [ROB_W-1:0]       _rs_rob_id,
  input  logic [XLEN-1:0]        _rs_r1,
  input  logic [XLEN-1:0]        _rs_sv,
  input  logic [XLEN-1:0]        _rs_imm,
  input  logic                   _rs_has_dep1,
  input  logic                   _rs_has_dep2,
  input  logic [ROB_W-1:0]       _rs_dep1,
  input  logic [ROB_W-1:0]       _rs_dep2,
  output logic                   _rs_full,
  input  logic [NWAKE-1:0]       _wk_ready,
  input  logic [NWAKE*ROB_W-1:0] _wk_rob_id,
  input  logic [NWAKE*XLEN-1:0]  _wk_value,
  output logic                   _lsb_valid,
  input  logic                   _lsb_accept,
  output logic [ROB_W-1:0]       _lsb_rob_id,
  output logic [6:0]             _lsb_type,
  output logic [XLEN-1:0]        _lsb_st_value,
  output logic [XLEN-1:0]        _lsb_ptr_value
);
  localparam int unsigned RW = $clog2(DEPTH);
  localparam int unsigned CW = RW + 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] pend1_q;
  logic [DEPTH-1:0] pend2_q;
  logic [ROB_W-1:0] dep1_q   [DEPTH];
  logic [ROB_W-1:0] dep2_q   [DEPTH];
  logic [XLEN-1:0]  v1_q     [DEPTH];
  logic [XLEN-1:0]  sv_q     [DEPTH];
  logic [XLEN-1:0]  imm_q    [DEPTH];
  logic [6:0]       type_q   [DEPTH];
  logic [ROB_W-1:0] rob_q    [DEPTH];
  logic [RW-1:0]    rank_q   [DEPTH];
  logic [CW-1:0]    count_q;

  logic [XLEN:0]    snp1 [DEPTH];
  logic [XLEN:0]    snp2 [DEPTH];
  logic [XLEN:0]    ins_snp1;
  logic [XLEN:0]    ins_snp2;
  logic             sel_valid;
  logic [RW-1:0]    sel_idx;
  logic [RW-1:0]    sel_rank;
  logic             free_valid;
  logic [RW-1:0]    free_idx;
  logic             ins;
  logic             load;
  logic [CW-1:0]    count_nxt;
  logic [RW-1:0]    ins_rank;

  // Broadcast match for one tag: {hit, value}; the lowest matching channel wins.
  function automatic logic [XLEN:0] snoop(input logic [ROB_W-1:0] tag);
    logic [XLEN:0] r;
    r = '0;
    for (int k = NWAKE - 1; k >= 0; k--) begin
      if (_wk_ready[k] && (_wk_rob_id[k*ROB_W +: ROB_W] == tag))
        r = {1'b1, _wk_value[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  // Oldest-ready selection, lowest free slot, and per-entry snoop results.
  always_comb begin
    logic cand;
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_rank   = '0;
    free_valid = 1'b0;
    free_idx   = '0;
    cand       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      snp1[i] = snoop(dep1_q[i]);
      snp2[i] = snoop(dep2_q[i]);
`ifdef LS_RS_STRICT_ORDER_EN
      cand = busy_q[i] && !pend1_q[i] && !pend2_q[i] && (rank_q[i] == '0);
`else
      cand = busy_q[i] && !pend1_q[i] && !pend2_q[i];
`endif
      if (cand && (!sel_valid || (rank_q[i] < sel_rank))) begin
        sel_valid = 1'b1;
        sel_idx   = RW'(i);
        sel_rank  = rank_q[i];
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_valid = 1'b1;
        free_idx   = RW'(i);
      end
    end
    ins_snp1  = snoop(_rs_dep1);
    ins_snp2  = snoop(_rs_dep2);
    ins       = _rs_ready && free_valid && (count_q < CW'(DEPTH));
    load      = sel_valid && (!_lsb_valid || _lsb_accept);
    count_nxt = count_q + CW'(ins) - CW'(load);
    ins_rank  = load ? RW'(count_q - CW'(1)) : RW'(count_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || _clear) begin
      busy_q         <= '0;
      pend1_q        <= '0;
      pend2_q        <= '0;
      count_q        <= '0;
      _rs_full       <= 1'b0;
      _lsb_valid     <= 1'b0;
      _lsb_rob_id    <= '0;
      _lsb_type      <= '0;
      _lsb_st_value  <= '0;
      _lsb_ptr_value <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i]) begin
          if (pend1_q[i] && snp1[i][XLEN]) begin
            v1_q[i]    <= snp1[i][XLEN-1:0];
            pend1_q[i] <= 1'b0;
          end
          if (pend2_q[i] && snp2[i][XLEN]) begin
            sv_q[i]    <= snp2[i][XLEN-1:0];
            pend2_q[i] <= 1'b0;
          end
          if (load && (rank_q[i] > sel_rank))
            rank_q[i] <= rank_q[i] - RW'(1);
        end
      end
      if (load) begin
        busy_q[sel_idx] <= 1'b0;
        _lsb_valid      <= 1'b1;
        _lsb_rob_id     <= rob_q[sel_idx];
        _lsb_type       <= type_q[sel_idx];
        _lsb_st_value   <= sv_q[sel_idx];
        _lsb_ptr_value  <= v1_q[sel_idx] + imm_q[sel_idx];
      end else if (_lsb_accept) begin
        _lsb_valid <= 1'b0;
      end
      // New entry overrides the snoop updates above for its (previously free) slot.
      if (ins) begin
        busy_q[free_idx]  <= 1'b1;
        pend1_q[free_idx] <= _rs_has_dep1 && !ins_snp1[XLEN];
        pend2_q[free_idx] <= _rs_has_dep2 && !ins_snp2[XLEN];
        v1_q[free_idx]    <= (_rs_has_dep1 && ins_snp1[XLEN]) ? ins_snp1[XLEN-1:0] : _rs_r1;
        sv_q[free_idx]    <= (_rs_has_dep2 && ins_snp2[XLEN]) ? ins_snp2[XLEN-1:0] : _rs_sv;
        dep1_q[free_idx]  <= _rs_dep1;
        dep2_q[free_idx]  <= _rs_dep2;
        imm_q[free_idx]   <= _rs_imm;
        type_q[free_idx]  <= _rs_type;
        rob_q[free_idx]   <= _rs_rob_id;
        rank_q[free_idx]  <= ins_rank;
      end
      count_q  <= count_nxt;
      _rs_full <= (count_nxt >= CW'(DEPTH - 1));
    end
  end

endmodule

// File: tb/tb_ls_rs_ordered.sv
// Scoreboard bench for ls_rs_ordered: expected issues queued at dispatch, compared on transfer.
module tb_ls_rs_ordered;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NWAKE = 5;

  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic [6:0]       typ;
    logic [XLEN-1:0]  ptr;
    logic [XLEN-1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  logic rs_ready = 1'b0;
  logic [6:0] rs_type = '0;
  logic [ROB_W-1:0] rs_rob_id = '0;
  logic [XLEN-1:0] rs_r1 = '0;
  logic [XLEN-1:0] rs_sv = '0;
  logic [XLEN-1:0] rs_imm = '0;
  logic rs_has_dep1 = 1'b0;
  logic rs_has_dep2 = 1'b0;
  logic [ROB_W-1:0] rs_dep1 = '0;
  logic [ROB_W-1:0] rs_dep2 = '0;
  logic rs_full;
  logic [NWAKE-1:0] wk_ready = '0;
  logic [NWAKE*ROB_W-1:0] wk_rob_id = '0;
  logic [NWAKE*XLEN-1:0] wk_value = '0;
  logic lsb_valid;
  logic lsb_accept = 1'b0;
  logic [ROB_W-1:0] lsb_rob_id;
  logic [6:0] lsb_type;
  logic [XLEN-1:0] lsb_st_value;
  logic [XLEN-1:0] lsb_ptr_value;

  int checks = 0;
  int errors = 0;
  int n_issued = 0;
  exp_t sb_q[$];

  ls_rs_ordered #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN), .NWAKE(NWAKE)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._clear(clear),
    ._rs_ready(rs_ready), ._rs_type(rs_type), ._rs_rob_id(rs_rob_id),
    ._rs_r1(rs_r1), ._rs_sv(rs_sv), ._rs_imm(rs_imm),
    ._rs_has_dep1(rs_has_dep1), ._rs_has_dep2(rs_has_dep2),
    ._rs_dep1(rs_dep1), ._rs_dep2(rs_dep2), ._rs_full(rs_full),
    ._wk_ready(wk_ready), ._wk_rob_id(wk_rob_id), ._wk_value(wk_value),
    ._lsb_valid(lsb_valid), ._lsb_accept(lsb_accept), ._lsb_rob_id(lsb_rob_id),
    ._lsb_type(lsb_type), ._lsb_st_value(lsb_st_value), ._lsb_ptr_value(lsb_ptr_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic insert(input logic [ROB_W-1:0] rob, input logic [6:0] typ,
                        input logic [XLEN-1:0] r1, input logic [XLEN-1:0] sv,
                        input logic [XLEN-1:0] imm, input logic hd1, input logic [ROB_W-1:0] d1,
                        input logic hd2, input logic [ROB_W-1:0] d2);
    rs_ready = 1'b1; rs_rob_id = rob; rs_type = typ; rs_r1 = r1; rs_sv = sv; rs_imm = imm;
    rs_has_dep1 = hd1; rs_dep1 = d1; rs_has_dep2 = hd2; rs_dep2 = d2;
    step();
    rs_ready = 1'b0; rs_has_dep1 = 1'b0; rs_has_dep2 = 1'b0;
  endtask

  task automatic set_wk(input int k, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] v);
    wk_ready[k] = 1'b1;
    wk_rob_id[k*ROB_W +: ROB_W] = tag;
    wk_value[k*XLEN +: XLEN] = v;
  endtask

  task automatic push(input logic [ROB_W-1:0] rob, input logic [6:0] typ,
                      input logic [XLEN-1:0] ptr, input logic [XLEN-1:0] st);
    exp_t e;
    e.rob = rob; e.typ = typ; e.ptr = ptr; e.st = st;
    sb_q.push_back(e);
  endtask

  // A transfer happens at the coming edge when the stage is valid, accepted and not frozen/flushed.
  always @(negedge clk) begin
    if (!rst && !clear && rdy && lsb_valid && lsb_accept) begin
      n_issued++;
      if (sb_q.size() == 0) begin
        check("unexpected_issue_rob", 64'(lsb_rob_id), 64'hFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("issue_rob", 64'(lsb_rob_id), 64'(e.rob));
        check("issue_type", 64'(lsb_type), 64'(e.typ));
        check("issue_ptr", 64'(lsb_ptr_value), 64'(e.ptr));
        check("issue_st", 64'(lsb_st_value), 64'(e.st));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    step(2);
    rst = 1'b0;
    check("rst_valid", 64'(lsb_valid), 0);
    check("rst_full", 64'(rs_full), 0);
    check("rst_ptr", 64'(lsb_ptr_value), 0);

    // Basic issue latency and effective address
    lsb_accept = 1'b1;
    push(5'd3, 7'h03, 32'h108, 32'h55);
    insert(5'd3, 7'h03, 32'h100, 32'h55, 32'h8, 0, 0, 0, 0);
    check("t1_not_yet", 64'(lsb_valid), 0);
    step();
    check("t1_valid", 64'(lsb_valid), 1);
    check("t1_ptr", 64'(lsb_ptr_value), 64'h108);
    check("t1_rob", 64'(lsb_rob_id), 3);
    check("t1_full", 64'(rs_full), 0);
    step(3);
    check("t1_drained", 64'(lsb_valid), 0);

    // Tag 0 dependency must wait for its broadcast; younger ready entry goes first
    base = n_issued;
    push(5'd2, 7'h23, 32'h204, 32'h22);
    push(5'd1, 7'h23, 32'h50, 32'h11);
    insert(5'd1, 7'h23, 32'h0, 32'h11, 32'h10, 1, 5'd0, 0, 0);
    insert(5'd2, 7'h23, 32'h200, 32'h22, 32'h4, 0, 0, 0, 0);
    step(3);
    check("t2_one_issued", 64'(n_issued - base), 1);
    set_wk(4, 5'd0, 32'h40);
    step();
    wk_ready = '0;
    step(3);
    check("t2_both_issued", 64'(n_issued - base), 2);

    // Insert bypass: two channels match, lowest channel value captured
    push(5'd5, 7'h23, 32'h300, 32'hA);
    set_wk(0, 5'd7, 32'hA);
    set_wk(2, 5'd7, 32'hB);
    insert(5'd5, 7'h23, 32'h300, 32'h0, 32'h0, 0, 0, 1, 5'd7);
    wk_ready = '0;
    step();
    check("t3_valid", 64'(lsb_valid), 1);
    check("t3_st", 64'(lsb_st_value), 64'hA);
    step(3);

    // Fill, full flag, ignored overflow insert, held output, age-ordered drain
    lsb_accept = 1'b0;
    base = n_issued;
    for (int i = 0; i < 8; i++) begin
      push(5'(8 + i), 7'h03, 32'h1000 + 32'(i * 4), 32'(i));
      insert(5'(8 + i), 7'h03, 32'h0, 32'(i), 32'(i * 4), 1, 5'd9, 0, 0);
      if (i == 5) check("t4_full_at6", 64'(rs_full), 0);
      if (i == 6) check("t4_full_at7", 64'(rs_full), 1);
    end
    check("t4_full_at8", 64'(rs_full), 1);
    insert(5'd31, 7'h03, 32'h7, 32'h7, 32'h7, 0, 0, 0, 0);
    set_wk(1, 5'd9, 32'h1000);
    step();
    wk_ready = '0;
    step();
    for (int c = 0; c < 10; c++) begin
      check("t4_hold_valid", 64'(lsb_valid), 1);
      check("t4_hold_rob", 64'(lsb_rob_id), 8);
      check("t4_hold_ptr", 64'(lsb_ptr_value), 64'h1000);
      step();
    end
    lsb_accept = 1'b1;
    step(12);
    check("t4_drain_count", 64'(n_issued - base), 8);
    check("t4_full_after", 64'(rs_full), 0);
    check("t4_valid_after", 64'(lsb_valid), 0);

    // Flush, then reset combined with rdy_in low: everything discarded
    for (int r = 0; r < 2; r++) begin
      lsb_accept = 1'b0;
      for (int i = 0; i < 5; i++) insert(5'(16 + i), 7'h23, 32'h20, 32'h1, 32'(i), 0, 0, 0, 0);
      step();
      check("t5_pre_valid", 64'(lsb_valid), 1);
      base = n_issued;
      if (r == 0) clear = 1'b1; else begin rst = 1'b1; rdy = 1'b0; end
      step();
      clear = 1'b0; rst = 1'b0; rdy = 1'b1;
      check("t5_valid", 64'(lsb_valid), 0);
      check("t5_full", 64'(rs_full), 0);
      check("t5_ptr", 64'(lsb_ptr_value), 0);
      lsb_accept = 1'b1;
      step(5);
      check("t5_no_issue", 64'(n_issued - base), 0);
    end

    // rdy_in low: broadcast lost and insert dropped
    base = n_issued;
    insert(5'd21, 7'h03, 32'h0, 32'h3, 32'h4, 1, 5'd12, 0, 0);
    rdy = 1'b0;
    set_wk(0, 5'd12, 32'h80);
    rs_ready = 1'b1; rs_rob_id = 5'd22; rs_r1 = 32'h9; rs_imm = 32'h0;
    step();
    rs_ready = 1'b0; wk_ready = '0; rdy = 1'b1;
    step(3);
    check("frz_lost", 64'(n_issued - base), 0);
    push(5'd21, 7'h03, 32'h84, 32'h3);
    set_wk(3, 5'd12, 32'h80);
    step();
    wk_ready = '0;
    step(3);
    check("frz_woken", 64'(n_issued - base), 1);

    // Oldest pending, younger ready
    base = n_issued;
`ifdef LS_RS_STRICT_ORDER_EN
    push(5'd24, 7'h23, 32'h608, 32'h1);
    push(5'd25, 7'h23, 32'h500, 32'h2);
`else
    push(5'd25, 7'h23, 32'h500, 32'h2);
    push(5'd24, 7'h23, 32'h608, 32'h1);
`endif
    insert(5'd24, 7'h23, 32'h0, 32'h1, 32'h8, 1, 5'd13, 0, 0);
    insert(5'd25, 7'h23, 32'h500, 32'h2, 32'h0, 0, 0, 0, 0);
    step(3);
`ifdef LS_RS_STRICT_ORDER_EN
    check("t6_before_wake", 64'(n_issued - base), 0);
`else
    check("t6_before_wake", 64'(n_issued - base), 1);
`endif
    set_wk(2, 5'd13, 32'h600);
    step();
    wk_ready = '0;
    step(4);
    check("t6_after_wake", 64'(n_issued - base), 2);
    check("sb_empty", 64'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
